serial_bit_feeder: RTL and testbench
====================================

// Module: serial_bit_feeder
// PURPOSE
//   Parallel-to-serial stage that feeds the serial pattern detector's data_i.
//   Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clk_i cycle.
//   A one-word holding buffer lets consecutive words stream with no idle gap between them.
//   Word boundaries are flagged on word_done_o.
// PARAMETERS
//   WIDTH      8   bits per word; legal range >= 2
//   MSB_FIRST  1   1: emit word[WIDTH-1] first; 0: emit word[0] first
//   IDLE_BIT   0   value driven on data_o while data_valid_o=0
// PORTS
//   clk_i         in   1      clock; all logic is rising-edge
//   reset_i       in   1      reset, asynchronous, active-low
//   word_i        in   WIDTH  parallel word; must be stable while word_valid_i=1 and word_ready_o=0
//   word_valid_i  in   1      word_i is valid
//   word_ready_o  out  1      block can accept a word; handshake = word_valid_i & word_ready_o
//   data_o        out  1      serial bit, registered; connects to the detector's data_i
//   data_valid_o  out  1      data_o carries a word bit this cycle
//   word_done_o   out  1      1-cycle pulse, coincident with the last bit of each word
//   busy_o        out  1      shifter active OR holding buffer occupied
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - Outputs: data_o=IDLE_BIT, data_valid_o=0, word_done_o=0, busy_o=0, word_ready_o=1.
//     - Shifter, bit counter and holding buffer are cleared; any word in flight is discarded.
//     - No partial bits are emitted after release.
//   Storage:
//     - Shift register plus bit counter bit_cnt (clog2(WIDTH) bits).
//     - Holding register hold_q with flag hold_v.
//     - word_ready_o = !hold_v, registered (no combinational path from word_valid_i).
//   FSM with two states:
//     - IDLE: data_valid_o=0.
//       On handshake: load word_i into shifter, bit_cnt=0, go to SHIFT.
//       The first bit appears on data_o in the next cycle (latency 1 from handshake).
//     - SHIFT: data_valid_o=1; bit_cnt counts the bit currently on data_o.
//       If bit_cnt < WIDTH-1: present the next bit, bit_cnt+1.
//       If bit_cnt == WIDTH-1: word_done_o=1 this cycle. Next cycle:
//         (a) hold_v=1: load hold_q into shifter, clear hold_v, stay in SHIFT.
//         (b) else, on handshake: load word_i directly, stay in SHIFT.
//         (c) else: go to IDLE; data_o returns to IDLE_BIT.
//   Holding buffer:
//     - A handshake while in SHIFT that is not case (b) writes hold_q and sets hold_v.
//     - hold_v clearing (case a) and a new write never occur in the same cycle, since ready=0 while hold_v=1.
//   Ordering and throughput:
//     - Words are emitted strictly in acceptance order.
//     - Sustained throughput is 1 word per WIDTH cycles with zero gap between words.
//     - Downstream sees a contiguous bit stream.
//   Bit order: MSB_FIRST=1 shifts left and outputs the MSB; MSB_FIRST=0 shifts right and outputs the LSB.
//   Reset mid-word: the word is truncated without word_done_o; the detector resets on the same reset_i.
//   busy_o = (state==SHIFT) | hold_v, registered with the state.
// TESTING
//   1. After reset, handshake 8'hA0 at cycle k
//      -> data_o 1,0,1,0,0,0,0,0 at k+1..k+8; data_valid_o=1 for exactly 8 cycles;
//         word_done_o at k+8; detector match_o pulses once.
//   2. word_valid_i held with 8'hFF then 8'h00
//      -> 16 contiguous valid bits (8 ones, 8 zeros), no gap;
//         word_ready_o=0 from the cycle after the 2nd accept until the hold register drains.
//   3. MSB_FIRST=0, word 8'h05 -> data_o 1,0,1,0,0,0,0,0; done on the 8th bit.
//   4. Three words 8'h11, 8'h22, 8'h33 offered with valid held through ready=0
//      -> exactly 24 bits out, in order, none dropped or duplicated; 3 word_done_o pulses.
//   5. reset_i low during bit 4 of 8'hFF
//      -> outputs take reset values immediately (async);
//         after release data_valid_o=0 and no residual bits until a new handshake.
//   6. Handshake in the same cycle as the last bit with hold empty (case b)
//      -> first bit of the new word follows on the next cycle; hold_v stays 0.

Source files
------------

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: accepts WIDTH-bit words over valid/ready and emits one bit per cycle.
// A one-word holding buffer lets back-to-back words stream without an idle gap.
module serial_bit_feeder #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             word_valid_i,
    output logic             word_ready_o,
    output logic             data_o,
    output logic             data_valid_o,
    output logic             word_done_o,
    output logic             busy_o
);

    localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_v_q, hold_v_d;
    logic             busy_q, busy_d;
    logic             handshake;
    logic             cur_bit;

    // ready is just the inverted buffer flag, so it never depends on word_valid_i
    assign handshake = word_valid_i & ~hold_v_q;
    assign cur_bit   = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            hold_q    <= '0;
            hold_v_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            hold_q    <= hold_d;
            hold_v_q  <= hold_v_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        hold_d    = hold_q;
        hold_v_d  = hold_v_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    shift_d   = word_i;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt_q != LAST) begin
                    if (MSB_FIRST) begin
                        shift_d = {shift_q[WIDTH-2:0], 1'b0};
                    end else begin
                        shift_d = {1'b0, shift_q[WIDTH-1:1]};
                    end
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (handshake) begin
                        hold_d   = word_i;
                        hold_v_d = 1'b1;
                    end
                end else if (hold_v_q) begin
                    shift_d   = hold_q;
                    hold_v_d  = 1'b0;
                    bit_cnt_d = '0;
                end else if (handshake) begin
                    shift_d   = word_i;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SHIFT) | hold_v_d;
    end

    assign word_ready_o = ~hold_v_q;
    assign data_valid_o = (state_q == SHIFT);
    assign data_o       = (state_q == SHIFT) ? cur_bit : IDLE_BIT;
    assign word_done_o  = (state_q == SHIFT) && (bit_cnt_q == LAST);
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: MSB-first and LSB-first instances share one stimulus and are
// compared every cycle against a queue-of-pending-bits model.
module tb_serial_bit_feeder;

    localparam int unsigned W = 8;

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b0;
    logic [W-1:0] word_i = '0;
    logic         word_valid_i = 1'b0;

    logic ready_m, data_m, dv_m, done_m, busy_m;
    logic ready_l, data_l, dv_l, done_l, busy_l;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc = 0;

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
        .clk_i(clk_i), .reset_i(reset_i), .word_i(word_i), .word_valid_i(word_valid_i),
        .word_ready_o(ready_m), .data_o(data_m), .data_valid_o(dv_m),
        .word_done_o(done_m), .busy_o(busy_m)
    );

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (
        .clk_i(clk_i), .reset_i(reset_i), .word_i(word_i), .word_valid_i(word_valid_i),
        .word_ready_o(ready_l), .data_o(data_l), .data_valid_o(dv_l),
        .word_done_o(done_l), .busy_o(busy_l)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Model: every accepted word appends its W bits to a queue; the head is what is on the wire.
    typedef struct {
        logic [W-1:0] w;
        int unsigned  idx;
    } ent_t;
    ent_t q[$];

    always @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            q.delete();
        end else begin
            automatic bit rdy = (q.size() <= W);
            cyc++;
            if (q.size() > 0) void'(q.pop_front());
            if (word_valid_i && rdy) begin
                for (int unsigned i = 0; i < W; i++) q.push_back('{word_i, i});
            end
        end
    end

    always @(negedge clk_i) begin
        if (reset_i) begin
            automatic bit          ev = (q.size() > 0);
            automatic logic        em = 1'b0;
            automatic logic        el = 1'b1;
            automatic bit          ed = 1'b0;
            if (ev) begin
                em = q[0].w[W-1-q[0].idx];
                el = q[0].w[q[0].idx];
                ed = (q[0].idx == W - 1);
            end
            check("m.valid", dv_m, ev);
            check("m.data", data_m, em);
            check("m.done", done_m, ed);
            check("m.ready", ready_m, q.size() <= W);
            check("m.busy", busy_m, ev);
            check("l.valid", dv_l, ev);
            check("l.data", data_l, el);
            check("l.done", done_l, ed);
            check("l.ready", ready_l, q.size() <= W);
            check("l.busy", busy_l, ev);
        end
    end

    typedef struct {
        logic        dm;
        logic        dl;
        logic        done;
        int unsigned c;
    } cap_t;
    cap_t cap[$];

    always @(negedge clk_i) begin
        if (reset_i && dv_m) cap.push_back('{data_m, data_l, done_m, cyc});
    end

    // Caller sits at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [W-1:0] w);
        automatic int unsigned n = 0;
        word_i = w;
        word_valid_i = 1'b1;
        while (!ready_m) begin
            @(negedge clk_i);
            n++;
            if (n > 64) begin
                check("send_timeout", 0, 1);
                word_valid_i = 1'b0;
                return;
            end
        end
        @(negedge clk_i);
        word_valid_i = 1'b0;
    endtask

    task automatic check_pattern(input string name, input logic [W-1:0] pat, input bit lsb);
        check({name, ".count"}, cap.size(), W);
        if (cap.size() == W) begin
            for (int unsigned i = 0; i < W; i++) begin
                check({name, ".bit"}, lsb ? cap[i].dl : cap[i].dm, pat[W-1-i]);
                check({name, ".done"}, cap[i].done, i == W - 1);
            end
        end
    endtask

    task automatic check_contig(input string name, input int unsigned n);
        check({name, ".count"}, cap.size(), n);
        if (cap.size() == n) begin
            for (int unsigned i = 1; i < n; i++) check({name, ".gap"}, cap[i].c, cap[0].c + i);
        end
    endtask

    initial begin
        automatic logic [W-1:0] pat = 8'b1010_0000;
        automatic int unsigned  dones;

        repeat (3) @(negedge clk_i);
        check("rst.data_m", data_m, 0);
        check("rst.data_l", data_l, 1);
        check("rst.valid", dv_m, 0);
        check("rst.done", done_m, 0);
        check("rst.busy", busy_m, 0);
        check("rst.ready", ready_m, 1);
        reset_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // 8'hA0 MSB-first
        cap.delete();
        send(8'hA0);
        repeat (10) @(negedge clk_i);
        check_pattern("t1", pat, 1'b0);

        // 8'h05 LSB-first reads 1,0,1,0,0,0,0,0
        cap.delete();
        send(8'h05);
        repeat (10) @(negedge clk_i);
        check_pattern("t3", pat, 1'b1);

        // FF then 00 with valid held: 16 contiguous bits
        cap.delete();
        send(8'hFF);
        send(8'h00);
        repeat (20) @(negedge clk_i);
        check_contig("t2", 16);
        if (cap.size() == 16) begin
            for (int unsigned i = 0; i < 16; i++) check("t2.bit", cap[i].dm, i < 8);
        end

        // three words held through ready=0
        cap.delete();
        send(8'h11);
        send(8'h22);
        send(8'h33);
        repeat (30) @(negedge clk_i);
        check_contig("t4", 24);
        if (cap.size() == 24) begin
            automatic logic [23:0] all = 24'h112233;
            dones = 0;
            for (int unsigned i = 0; i < 24; i++) begin
                check("t4.bit", cap[i].dm, all[23-i]);
                if (cap[i].done) dones++;
            end
            check("t4.dones", dones, 3);
        end

        // handshake coincident with last bit, hold empty
        cap.delete();
        send(8'hA5);
        repeat (7) @(negedge clk_i);
        check("t6.last_done", done_m, 1);
        check("t6.ready_at_last", ready_m, 1);
        send(8'h3C);
        for (int unsigned i = 0; i < 9; i++) begin
            check("t6.ready", ready_m, 1);
            @(negedge clk_i);
        end
        check_contig("t6", 16);

        // async reset during bit 4 of 8'hFF
        cap.delete();
        send(8'hFF);
        repeat (3) @(negedge clk_i);
        #2 reset_i = 1'b0;
        #1;
        check("t5.data_m", data_m, 0);
        check("t5.data_l", data_l, 1);
        check("t5.valid", dv_m, 0);
        check("t5.done", done_m, 0);
        check("t5.busy", busy_m, 0);
        check("t5.ready", ready_m, 1);
        @(negedge clk_i);
        reset_i = 1'b1;
        cap.delete();
        repeat (6) @(negedge clk_i);
        check("t5.residual", cap.size(), 0);

        // randomized traffic with sparse resets
        for (int unsigned it = 0; it < 250; it++) begin
            repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 10) : 0) @(negedge clk_i);
            if ($urandom_range(0, 60) == 0) begin
                #3 reset_i = 1'b0;
                @(negedge clk_i);
                reset_i = 1'b1;
            end
            send(W'($urandom));
        end
        repeat (30) @(negedge clk_i);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
